serial_adder: RTL

//  Bit-serial WIDTH-bit adder: one full-adder cell, a carry flip-flop, a down counter.

---
 rtl/serial_adder.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one FA cell, carry flop and down counter, LSB first.
// Latency WIDTH+1 cycles from accepted start to done; no backpressure, start ignored while ready=0.
// Optional subtract mode under `define SERIAL_ADDER_SUB_EN (adds the sub port).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] b_load;
    logic             carry_init;

    // Single full-adder cell shared across all bit positions.
    assign fa_s  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_co = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as A + ~B + 1: invert B on load and seed the carry with 1.
    assign b_load     = sub ? ~B : B;
    assign carry_init = sub;
`else
    assign b_load     = B;
    assign carry_init = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sr_q  <= A;
                        b_sr_q  <= b_load;
                        carry_q <= carry_init;
                        cnt_q   <= CW'(WIDTH - 1);
                    end
                end
                ST_RUN: begin
                    a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == '0) cout_q <= fa_co;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
